i2s_transmitter: RTL and testbench

- Downstream stage of the 8-band equalizer. Takes the summed mono equalizer output, one sample per 64-cycle equalizer frame, and serializes it as a standard I2S stereo stream to an external DAC.
- The same sample is sent on the left and right channels.
- A one-deep pending buffer decouples the sample strobe from the serial frame. Underrun and overrun are flagged.

---
 rtl/i2s_transmitter_if.sv | 23 ++
 rtl/i2s_transmitter.sv | 136 +++++++++++++
 tb/tb_i2s_transmitter.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_transmitter_if.sv
// Sample-strobe input and I2S serial output bundle for the equalizer's DAC stage.
interface i2s_transmitter_if #(
  parameter int SAMPLE_BITS = 16
);
  logic                          sample_valid;
  logic signed [SAMPLE_BITS-1:0] sample_in;
  logic                          bclk;
  logic                          lrclk;
  logic                          sdata;
  logic                          frame_start;
  logic                          underrun;
  logic                          overrun;

  modport master (
    output sample_valid, sample_in,
    input  bclk, lrclk, sdata, frame_start, underrun, overrun
  );

  modport slave (
    input  sample_valid, sample_in,
    output bclk, lrclk, sdata, frame_start, underrun, overrun
  );
endinterface

// File: rtl/i2s_transmitter.sv
// Serializes one mono equalizer sample per frame as an I2S stereo stream (same word left and right),
// with a one-deep pending buffer between the sample strobe and the frame boundary.
module i2s_transmitter #(
  parameter int SAMPLE_BITS   = 16,
  parameter int SLOT_BITS     = 16,
  parameter int BCLK_HALF_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_enable,
  i2s_transmitter_if.slave i2s
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] RIGHT_SLOT = BIT_W'(SLOT_BITS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                        state;
  logic [DIV_W-1:0]              div_cnt;
  logic [BIT_W-1:0]              bit_n;
  logic [FRAME_BITS-1:0]         frame_word;
  logic [FRAME_BITS-1:0]         shift_reg;
  logic signed [SAMPLE_BITS-1:0] pending;
  logic                          pending_vld;

  logic bclk_r, lrclk_r, sdata_r, frame_start_r, underrun_r, overrun_r;

  logic [DIV_W-1:0] div_nxt;
  logic [BIT_W-1:0] bit_nxt;
  logic             bclk_nxt;
  logic             fall;
  logic             load;

  // Sample left-justified in its slot, zero padded, duplicated for both channels.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic signed [SAMPLE_BITS-1:0] s);
    logic [SLOT_BITS-1:0] slot;
    slot = '0;
    slot[SLOT_BITS-1 -: SAMPLE_BITS] = s;
    return {slot, slot};
  endfunction

  always_comb begin
    div_nxt  = div_cnt + 1'b1;
    bclk_nxt = bclk_r;
    bit_nxt  = bit_n;
    fall     = 1'b0;
    if (div_cnt == DIV_LAST) begin
      div_nxt  = '0;
      bclk_nxt = ~bclk_r;
      if (bclk_r) begin
        fall    = 1'b1;
        bit_nxt = (bit_n == BIT_LAST) ? '0 : bit_n + 1'b1;
      end
    end
    load = fall && (bit_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_n         <= '0;
      pending_vld   <= 1'b0;
      bclk_r        <= 1'b0;
      lrclk_r       <= 1'b0;
      sdata_r       <= 1'b0;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
      overrun_r     <= 1'b0;
    end else if (clk_enable) begin
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
      overrun_r     <= 1'b0;
      case (state)
        IDLE: begin
          if (i2s.sample_valid) begin
            state         <= RUN;
            frame_word    <= build_frame(i2s.sample_in);
            shift_reg     <= build_frame(i2s.sample_in);
            div_cnt       <= '0;
            bit_n         <= '0;
            bclk_r        <= 1'b0;
            lrclk_r       <= 1'b0;
            sdata_r       <= 1'b0;
            frame_start_r <= 1'b1;
            pending_vld   <= 1'b0;
          end
        end
        RUN: begin
          div_cnt <= div_nxt;
          bit_n   <= bit_nxt;
          bclk_r  <= bclk_nxt;
          // Data and word select only move on bclk falling edges; the shifter's MSB
          // reaches F[0] by the wrap, giving the one-bit I2S delay for free.
          if (fall) begin
            lrclk_r   <= (bit_nxt >= RIGHT_SLOT);
            sdata_r   <= shift_reg[FRAME_BITS-1];
            shift_reg <= shift_reg << 1;
          end
          if (load) begin
            frame_start_r <= 1'b1;
            if (pending_vld) begin
              frame_word <= build_frame(pending);
              shift_reg  <= build_frame(pending);
            end else begin
              shift_reg  <= frame_word;
              underrun_r <= 1'b1;
            end
          end
          // A load on the same edge consumes the old pending value, so no overrun then.
          if (i2s.sample_valid) begin
            pending     <= i2s.sample_in;
            pending_vld <= 1'b1;
            overrun_r   <= pending_vld && !load;
          end else if (load) begin
            pending_vld <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i2s.bclk        = bclk_r;
  assign i2s.lrclk       = lrclk_r;
  assign i2s.sdata       = sdata_r;
  assign i2s.frame_start = frame_start_r;
  assign i2s.underrun    = underrun_r;
  assign i2s.overrun     = overrun_r;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: default instance plus a wide-slot, divided-bclk instance.
module tb_i2s_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [1:0]       rst_v;
  logic [1:0]       en;
  logic [1:0]       sv;
  logic [1:0][15:0] sin;
  logic [1:0]       bclk_w, lrclk_w, sdata_w, fs_w, ur_w, or_w;
  int               fs_cnt[2];
  int               ur_cnt[2];
  int               or_cnt[2];
  logic [15:0]      q0[$];
  logic [15:0]      q1[$];

  i2s_transmitter_if #(.SAMPLE_BITS(16)) if0 ();
  i2s_transmitter_if #(.SAMPLE_BITS(16)) if1 ();

  assign if0.sample_valid = sv[0];
  assign if0.sample_in    = sin[0];
  assign if1.sample_valid = sv[1];
  assign if1.sample_in    = sin[1];
  assign bclk_w[0]  = if0.bclk;
  assign lrclk_w[0] = if0.lrclk;
  assign sdata_w[0] = if0.sdata;
  assign fs_w[0]    = if0.frame_start;
  assign ur_w[0]    = if0.underrun;
  assign or_w[0]    = if0.overrun;
  assign bclk_w[1]  = if1.bclk;
  assign lrclk_w[1] = if1.lrclk;
  assign sdata_w[1] = if1.sdata;
  assign fs_w[1]    = if1.frame_start;
  assign ur_w[1]    = if1.underrun;
  assign or_w[1]    = if1.overrun;

  i2s_transmitter #(.SAMPLE_BITS(16), .SLOT_BITS(16), .BCLK_HALF_DIV(1)) dut0 (
    .clk        (clk),
    .rst        (rst_v[0]),
    .clk_enable (en[0]),
    .i2s        (if0.slave)
  );

  i2s_transmitter #(.SAMPLE_BITS(16), .SLOT_BITS(24), .BCLK_HALF_DIV(2)) dut1 (
    .clk        (clk),
    .rst        (rst_v[1]),
    .clk_enable (en[1]),
    .i2s        (if1.slave)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int q_size(input int idx);
    return (idx == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [15:0] q_front(input int idx);
    return (idx == 0) ? q0[0] : q1[0];
  endfunction

  task automatic q_pop(input int idx);
    if (idx == 0) void'(q0.pop_front());
    else          void'(q1.pop_front());
  endtask

  task automatic q_push(input int idx, input logic [15:0] v);
    if (idx == 0) q0.push_back(v);
    else          q1.push_back(v);
  endtask

  // Expected {bclk, lrclk, sdata} at enabled-cycle index k of a frame holding f.
  function automatic logic [2:0] exp_out(input int k, input int h, input int s,
                                         input logic [47:0] f, input logic prev0);
    int   n;
    logic b, l, d;
    n = (k / (2 * h)) % (2 * s);
    b = ((k / h) % 2) == 1;
    l = (n >= s);
    d = (n == 0) ? prev0 : f[2 * s - n];
    return {b, l, d};
  endfunction

  // I2S receiver: the bit sampled on the first rising bclk after lrclk changes closes the previous word.
  task automatic monitor(input int idx, input int s, input int w);
    logic        en_e, rs, prev_b, prev_lr, have_left;
    logic [31:0] sr, slot, got, pad;
    prev_b = 1'b0; prev_lr = 1'b0; have_left = 1'b0; sr = '0;
    forever begin
      @(posedge clk);
      en_e = en[idx];
      rs   = rst_v[idx];
      #1;
      if (rs) begin
        prev_b = 1'b0; prev_lr = 1'b0; have_left = 1'b0; sr = '0;
        continue;
      end
      if (!en_e) continue;
      if (fs_w[idx]) fs_cnt[idx]++;
      if (ur_w[idx]) ur_cnt[idx]++;
      if (or_w[idx]) or_cnt[idx]++;
      if (bclk_w[idx] && !prev_b) begin
        sr = {sr[30:0], sdata_w[idx]};
        if (lrclk_w[idx] != prev_lr) begin
          slot = sr & ((32'h1 << s) - 32'h1);
          got  = slot >> (s - w);
          pad  = slot & ((32'h1 << (s - w)) - 32'h1);
          if (lrclk_w[idx]) begin
            if (q_size(idx) != 0) begin
              check("sb_left", got, 32'(q_front(idx)));
              check("sb_pad", pad, 32'h0);
              have_left = 1'b1;
            end
          end else if (have_left) begin
            check("sb_right", got, 32'(q_front(idx)));
            q_pop(idx);
            have_left = 1'b0;
          end
        end
        prev_lr = lrclk_w[idx];
      end
      prev_b = bclk_w[idx];
    end
  endtask

  initial monitor(0, 16, 16);
  initial monitor(1, 24, 16);

  task automatic do_reset(input int idx);
    rst_v[idx] = 1'b1;
    sv[idx]    = 1'b0;
    repeat (2) @(negedge clk);
    rst_v[idx] = 1'b0;
    if (idx == 0) q0.delete();
    else          q1.delete();
    fs_cnt[idx] = 0; ur_cnt[idx] = 0; or_cnt[idx] = 0;
  endtask

  task automatic strobe(input int idx, input logic [15:0] v, input bit push);
    sin[idx] = v;
    sv[idx]  = 1'b1;
    @(negedge clk);
    sv[idx]  = 1'b0;
    if (push) q_push(idx, v);
  endtask

  task automatic wait_drain(input int idx, input int budget, input string name);
    int c;
    c = 0;
    while (q_size(idx) != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (q_size(idx) != 0) begin
      failures++;
      $display("FAIL %s: %0d frames still expected after %0d cycles", name, q_size(idx), budget);
    end
  endtask

  task automatic check_idle(input int idx, input string name);
    check(name, 32'({bclk_w[idx], lrclk_w[idx], sdata_w[idx], fs_w[idx], ur_w[idx], or_w[idx]}), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  logic [47:0] f1;
  logic [47:0] f5;
  logic [5:0]  cur, snap;
  int          k;
  logic        en_now, en_prev;

  initial begin
    rst_v = 2'b11; en = 2'b11; sv = 2'b00; sin = '0;
    fork
      do_reset(0);
      do_reset(1);
    join

    // Reset state and idle hold
    check_idle(0, "rst_outputs0");
    check_idle(1, "rst_outputs1");
    repeat (5) @(negedge clk);
    check_idle(0, "idle_hold");

    // Test 1: single 8001 frame, defaults
    f1 = 48'h0000_8001_8001;
    strobe(0, 16'h8001, 1'b1);
    for (int kk = 0; kk <= 64; kk++) begin
      check("t1_out", 32'({bclk_w[0], lrclk_w[0], sdata_w[0]}),
            32'(exp_out(kk, 1, 16, f1, (kk >= 64) ? f1[0] : 1'b0)));
      if (kk == 0 || kk == 64) check("t1_frame_start", 32'(fs_w[0]), 32'h1);
      if (kk == 0)  check("t1_no_underrun_at_start", 32'(ur_w[0]), 32'h0);
      if (kk == 64) check("t1_underrun_retransmit", 32'(ur_w[0]), 32'h1);
      @(negedge clk);
    end
    wait_drain(0, 100, "t1_drain");

    // Tests 2 and 3: back-to-back frames, then retransmission of 00FF
    do_reset(0);
    strobe(0, 16'h1234, 1'b1);
    repeat (31) @(negedge clk);
    strobe(0, 16'hFFFF, 1'b1);
    repeat (63) @(negedge clk);
    strobe(0, 16'h00FF, 1'b1);
    q_push(0, 16'h00FF);
    repeat (54) @(negedge clk);
    check("t2_underrun_cnt", 32'(ur_cnt[0]), 32'd0);
    check("t2_overrun_cnt", 32'(or_cnt[0]), 32'd0);
    check("t2_frame_cnt", 32'(fs_cnt[0]), 32'd3);
    repeat (50) @(negedge clk);
    check("t3_underrun_cnt1", 32'(ur_cnt[0]), 32'd1);
    check("t3_frame_cnt", 32'(fs_cnt[0]), 32'd4);
    repeat (64) @(negedge clk);
    check("t3_underrun_cnt2", 32'(ur_cnt[0]), 32'd2);
    wait_drain(0, 200, "t23_drain");

    // Test 4: overrun within one frame
    do_reset(0);
    strobe(0, 16'h1111, 1'b1);
    repeat (9) @(negedge clk);
    strobe(0, 16'hAAAA, 1'b0);
    repeat (9) @(negedge clk);
    strobe(0, 16'h5555, 1'b1);
    repeat (20) @(negedge clk);
    check("t4_overrun_cnt", 32'(or_cnt[0]), 32'd1);
    check("t4_underrun_cnt", 32'(ur_cnt[0]), 32'd0);
    wait_drain(0, 200, "t4_drain");

    // Test 5: H=2, S=24 with clk_enable toggling every cycle
    do_reset(1);
    f5 = {16'hBEEF, 8'h00, 16'hBEEF, 8'h00};
    strobe(1, 16'hBEEF, 1'b1);
    k = 0;
    en_prev = 1'b1;
    snap = '0;
    for (int c = 0; c < 500 && k <= 192; c++) begin
      cur = {bclk_w[1], lrclk_w[1], sdata_w[1], fs_w[1], ur_w[1], or_w[1]};
      if (!en_prev) check("t5_freeze", 32'(cur), 32'(snap));
      check("t5_out", 32'(cur[5:3]), 32'(exp_out(k, 2, 24, f5, (k >= 192) ? f5[0] : 1'b0)));
      if (k == 192) begin
        check("t5_frame_start_192", 32'(fs_w[1]), 32'h1);
        check("t5_disabled_strobe_ignored", 32'(ur_w[1]), 32'h1);
      end
      snap   = cur;
      en_now = c[0];
      en[1]  = en_now;
      if (c == 100) begin
        sin[1] = 16'h0F0F;
        sv[1]  = 1'b1;
      end
      @(negedge clk);
      sv[1] = 1'b0;
      if (en_now) k++;
      en_prev = en_now;
    end
    check("t5_reached_frame_end", 32'(k > 192), 32'h1);
    en[1] = 1'b1;
    wait_drain(1, 400, "t5_drain");

    // Test 6: reset at bit period 10, then restart
    do_reset(0);
    strobe(0, 16'h7777, 1'b1);
    repeat (20) @(negedge clk);
    check("t6_pre_reset_lrclk", 32'(lrclk_w[0]), 32'h0);
    rst_v[0] = 1'b1;
    q0.delete();
    @(negedge clk);
    rst_v[0] = 1'b0;
    check_idle(0, "t6_reset_outputs");
    fs_cnt[0] = 0;
    repeat (70) @(negedge clk);
    check_idle(0, "t6_idle_after_reset");
    check("t6_no_frames_in_idle", 32'(fs_cnt[0]), 32'd0);
    strobe(0, 16'h1357, 1'b1);
    check("t6_restart_fs", 32'(fs_w[0]), 32'h1);
    check("t6_restart_lines", 32'({bclk_w[0], lrclk_w[0], sdata_w[0]}), 32'h0);
    @(negedge clk);
    check("t6_restart_bclk", 32'(bclk_w[0]), 32'h1);
    wait_drain(0, 200, "t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
